redmule_tile_sequencer: RTL and testbench

Parametrised tile-level control FSM for the RedMulE engine, the successor to the single-mode controller FSM. It sequences weight-row loading, the array compute and drain, Z-buffer fill and Z store over a programmable number of output tiles. New capabilities over the previous controller:
- optional Y-preload (accumulate-onto-Y) mode
- synchronous abort
- zero-size job bypass
- exported tile index

It sits between the register-file/tiler (configuration, start) and the engine/scheduler/Z-buffer (handshakes).

---
 rtl/redmule_tile_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_redmule_tile_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/redmule_tile_sequencer.sv
// redmule_tile_sequencer
// Tile-level control FSM for the RedMulE engine. Sequences an optional
// Y preload, the first weight-row load, compute and drain, Z-buffer fill
// and Z store over a programmable number of output tiles.
//
// Handshakes: every *_i event input (w_loaded_i, y_loaded_i, z_full_i,
// z_empty_i, reg_enable_i) is a single-cycle strobe sampled on the rising
// clock edge while the FSM sits in the state that consumes it; the request
// outputs (y_load_o, first_load_o, storing_o) stay high for as long as the
// FSM waits in the matching state, and there is no separate ready signal.
//
// Ports:
//   clk_i, rst_ni, clear_i        clock, async active-low reset, soft clear
//   start_i, cfg_*_i              job start and configuration (latched in IDLE)
//   abort_i                       abort current job
//   reg_enable_i                  engine advance strobe
//   w_loaded_i, y_loaded_i        weight row / Y tile delivered
//   z_full_i, z_empty_i           Z buffer full / emptied
//   busy_o, done_o, aborted_o     job status
//   first_load_o, y_load_o,
//   storing_o, z_fill_o           scheduler / Z-buffer controls
//   w_shift_o, accumulate_o,
//   flush_o, z_buffer_clk_en_o    engine controls
//   tile_idx_o                    index of the current tile
module redmule_tile_sequencer #(
  parameter int Height      = 4,
  parameter int NumPipeRegs = 3,
  parameter int CntWidth    = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic [CntWidth-1:0] cfg_w_iters_i,
  input  logic [CntWidth-1:0] cfg_tot_stores_i,
  input  logic                cfg_y_load_i,
  input  logic                abort_i,
  input  logic                reg_enable_i,
  input  logic                w_loaded_i,
  input  logic                y_loaded_i,
  input  logic                z_full_i,
  input  logic                z_empty_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                aborted_o,
  output logic                first_load_o,
  output logic                y_load_o,
  output logic                storing_o,
  output logic                z_fill_o,
  output logic                w_shift_o,
  output logic                accumulate_o,
  output logic                flush_o,
  output logic                z_buffer_clk_en_o,
  output logic [CntWidth-1:0] tile_idx_o
);

  localparam int DrainW = $clog2((NumPipeRegs + 1) * Height) + 1;
  localparam logic [DrainW-1:0]   DrainLast = DrainW'(Height - 1);
  localparam logic [CntWidth-1:0] HeightC   = CntWidth'(Height);

  typedef enum logic [2:0] {
    IDLE, PRELOAD_Y, FIRST_LOAD, COMPUTING, BUFFERING, STORING, FINISHED
  } state_e;

  state_e              state_q, state_d;
  logic [CntWidth-1:0] w_iters_q, w_iters_d;
  logic [CntWidth-1:0] tot_stores_q, tot_stores_d;
  logic                y_mode_q, y_mode_d;
  logic [CntWidth-1:0] row_cnt_q, row_cnt_d;
  logic [CntWidth-1:0] tile_idx_q, tile_idx_d;
  logic [DrainW-1:0]   drain_cnt_q, drain_cnt_d;
  logic                last_row_q, last_row_d;
  logic                accumulate_q, accumulate_d;
  logic                aborted_q, aborted_d;

  logic [CntWidth-1:0] row_inc;
  logic [DrainW-1:0]   drain_inc;
  logic                last_row_now;
  logic                abort_hit;

  assign row_inc   = row_cnt_q + CntWidth'(1);
  assign drain_inc = drain_cnt_q + DrainW'(1);
  // The last row is recognised in the same cycle row_cnt reaches w_iters,
  // so drain counting starts without waiting for the registered flag.
  assign last_row_now = last_row_q || (row_cnt_q == w_iters_q);
  assign abort_hit = abort_i && (state_q != IDLE) && (state_q != FINISHED);

  always_comb begin
    state_d      = state_q;
    w_iters_d    = w_iters_q;
    tot_stores_d = tot_stores_q;
    y_mode_d     = y_mode_q;
    row_cnt_d    = row_cnt_q;
    tile_idx_d   = tile_idx_q;
    drain_cnt_d  = drain_cnt_q;
    last_row_d   = last_row_q;
    accumulate_d = accumulate_q;
    aborted_d    = aborted_q;

    if (abort_hit) begin
      // Abort pre-empts every other update in this cycle.
      state_d   = FINISHED;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          row_cnt_d  = '0;
          tile_idx_d = '0;
          if (start_i) begin
            w_iters_d    = cfg_w_iters_i;
            tot_stores_d = cfg_tot_stores_i;
            y_mode_d     = cfg_y_load_i;
            aborted_d    = 1'b0;
            if (cfg_w_iters_i == '0 || cfg_tot_stores_i == '0) state_d = FINISHED;
            else if (cfg_y_load_i) state_d = PRELOAD_Y;
            else state_d = FIRST_LOAD;
          end
        end
        PRELOAD_Y: begin
          if (y_loaded_i) begin
            accumulate_d = 1'b1;
            // Only the first tile needs an explicit first load; later tiles
            // rely on the scheduler's prefetch.
            state_d = (tile_idx_q == '0) ? FIRST_LOAD : COMPUTING;
          end
        end
        FIRST_LOAD: begin
          if (w_loaded_i) begin
            row_cnt_d = CntWidth'(1);
            if (HeightC == CntWidth'(1)) accumulate_d = 1'b1;
            state_d = COMPUTING;
          end
        end
        COMPUTING: begin
          if (w_loaded_i) begin
            row_cnt_d = row_inc;
            if (row_inc == HeightC) accumulate_d = 1'b1;
          end
          if (row_cnt_q == w_iters_q) last_row_d = 1'b1;
          if (last_row_now && reg_enable_i) begin
            drain_cnt_d = drain_inc;
            // Leave on the (Height-1)th enabled drain cycle.
            if (drain_inc == DrainLast) begin
              drain_cnt_d = '0;
              last_row_d  = 1'b0;
              if (!y_mode_q) accumulate_d = 1'b0;
              state_d = BUFFERING;
            end
          end
        end
        BUFFERING: begin
          if (w_loaded_i) row_cnt_d = row_inc;
          // z_empty_i is not looked at here, so z_full_i wins.
          if (z_full_i) state_d = STORING;
        end
        STORING: begin
          if (w_loaded_i) row_cnt_d = row_inc;
          if (z_empty_i) begin
            tile_idx_d = tile_idx_q + CntWidth'(1);
            if (tile_idx_q == tot_stores_q - CntWidth'(1)) begin
              state_d = FINISHED;
            end else begin
              row_cnt_d = '0;
              state_d   = y_mode_q ? PRELOAD_Y : COMPUTING;
            end
          end
        end
        FINISHED: begin
          row_cnt_d    = '0;
          tile_idx_d   = '0;
          drain_cnt_d  = '0;
          last_row_d   = 1'b0;
          accumulate_d = 1'b0;
          state_d      = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      w_iters_q    <= '0;
      tot_stores_q <= '0;
      y_mode_q     <= 1'b0;
      row_cnt_q    <= '0;
      tile_idx_q   <= '0;
      drain_cnt_q  <= '0;
      last_row_q   <= 1'b0;
      accumulate_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else if (clear_i) begin
      state_q      <= IDLE;
      w_iters_q    <= '0;
      tot_stores_q <= '0;
      y_mode_q     <= 1'b0;
      row_cnt_q    <= '0;
      tile_idx_q   <= '0;
      drain_cnt_q  <= '0;
      last_row_q   <= 1'b0;
      accumulate_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_iters_q    <= w_iters_d;
      tot_stores_q <= tot_stores_d;
      y_mode_q     <= y_mode_d;
      row_cnt_q    <= row_cnt_d;
      tile_idx_q   <= tile_idx_d;
      drain_cnt_q  <= drain_cnt_d;
      last_row_q   <= last_row_d;
      accumulate_q <= accumulate_d;
      aborted_q    <= aborted_d;
    end
  end

  always_comb begin
    busy_o            = (state_q != IDLE) && (state_q != FINISHED);
    done_o            = (state_q == FINISHED);
    flush_o           = (state_q == FINISHED);
    first_load_o      = (state_q == FIRST_LOAD);
    y_load_o          = (state_q == PRELOAD_Y);
    storing_o         = (state_q == STORING);
    z_buffer_clk_en_o = (state_q == BUFFERING) || (state_q == STORING);
    z_fill_o          = (state_q == BUFFERING) && reg_enable_i;
    w_shift_o         = (state_q == COMPUTING);
  end

  assign accumulate_o = accumulate_q;
  assign aborted_o    = aborted_q;
  assign tile_idx_o   = tile_idx_q;

endmodule

// File: tb/tb_redmule_tile_sequencer.sv
// Directed testbench for redmule_tile_sequencer (Height=4, CntWidth=16).
module tb_redmule_tile_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [15:0] cfg_w_iters = '0;
  logic [15:0] cfg_tot_stores = '0;
  logic        cfg_y_load = 1'b0;
  logic        abort = 1'b0;
  logic        reg_enable = 1'b0;
  logic        w_loaded = 1'b0;
  logic        y_loaded = 1'b0;
  logic        z_full = 1'b0;
  logic        z_empty = 1'b0;
  logic        busy, done, aborted, first_load, y_load, storing, z_fill;
  logic        w_shift, accumulate, flush, z_buffer_clk_en;
  logic [15:0] tile_idx;

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected test end");
    $fatal(1);
  end

  redmule_tile_sequencer #(.Height(4), .NumPipeRegs(3), .CntWidth(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .start_i(start),
    .cfg_w_iters_i(cfg_w_iters), .cfg_tot_stores_i(cfg_tot_stores),
    .cfg_y_load_i(cfg_y_load), .abort_i(abort), .reg_enable_i(reg_enable),
    .w_loaded_i(w_loaded), .y_loaded_i(y_loaded), .z_full_i(z_full),
    .z_empty_i(z_empty), .busy_o(busy), .done_o(done), .aborted_o(aborted),
    .first_load_o(first_load), .y_load_o(y_load), .storing_o(storing),
    .z_fill_o(z_fill), .w_shift_o(w_shift), .accumulate_o(accumulate),
    .flush_o(flush), .z_buffer_clk_en_o(z_buffer_clk_en), .tile_idx_o(tile_idx)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_w();
    w_loaded = 1'b1; tick(); w_loaded = 1'b0;
  endtask

  task automatic pulse_en();
    reg_enable = 1'b1; tick(); reg_enable = 1'b0;
  endtask

  task automatic pulse_y();
    y_loaded = 1'b1; tick(); y_loaded = 1'b0;
  endtask

  task automatic pulse_zf();
    z_full = 1'b1; tick(); z_full = 1'b0;
  endtask

  task automatic pulse_ze();
    z_empty = 1'b1; tick(); z_empty = 1'b0;
  endtask

  task automatic drain3();
    repeat (3) pulse_en();
  endtask

  task automatic start_job(input logic [15:0] w, input logic [15:0] t, input logic y);
    cfg_w_iters = w; cfg_tot_stores = t; cfg_y_load = y;
    start = 1'b1; tick(); start = 1'b0;
    cfg_w_iters = '0; cfg_tot_stores = '0; cfg_y_load = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_tile;
    repeat (3) tick();
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    check_eq("reset_tile", tile_idx, 0);
    check_eq("reset_acc", accumulate, 0);
    check_eq("reset_zbuf", z_buffer_clk_en, 0);
    rst_n = 1'b1;
    tick();

    // basic job: w_iters=8, tot_stores=2, no Y
    exp_q.push_back(16'd1);
    exp_q.push_back(16'd2);
    start_job(16'd8, 16'd2, 1'b0);
    check_eq("basic_busy", busy, 1);
    check_eq("basic_first_load", first_load, 1);
    pulse_w();
    check_eq("basic_computing", w_shift, 1);
    pulse_w(); pulse_w();
    check_eq("basic_acc_row3", accumulate, 0);
    pulse_w();
    check_eq("basic_acc_row4", accumulate, 1);
    repeat (4) pulse_w();
    repeat (10) tick();
    check_eq("drain_hold_low", z_buffer_clk_en, 0);
    pulse_en(); pulse_en();
    check_eq("drain_after2", z_buffer_clk_en, 0);
    pulse_en();
    check_eq("drain_after3_buf", z_buffer_clk_en, 1);
    check_eq("buf_acc_cleared", accumulate, 0);
    reg_enable = 1'b1; #1;
    check_eq("z_fill_en", z_fill, 1);
    reg_enable = 1'b0; #1;
    check_eq("z_fill_dis", z_fill, 0);
    z_full = 1'b1; z_empty = 1'b1; tick(); z_full = 1'b0; z_empty = 1'b0;
    check_eq("full_wins_storing", storing, 1);
    check_eq("full_wins_tile", tile_idx, 0);
    pulse_ze();
    exp_tile = exp_q.pop_front();
    check_eq("basic_tile1", tile_idx, exp_tile);
    check_eq("basic_no_first_load", first_load, 0);
    check_eq("basic_tile1_busy", busy, 1);
    repeat (8) pulse_w();
    drain3();
    pulse_zf();
    pulse_ze();
    exp_tile = exp_q.pop_front();
    check_eq("basic_done", done, 1);
    check_eq("basic_flush", flush, 1);
    check_eq("basic_done_busy", busy, 0);
    check_eq("basic_tile2", tile_idx, exp_tile);
    tick();
    check_eq("basic_done_once", done, 0);
    check_eq("basic_tile_clr", tile_idx, 0);

    // Y mode: w_iters=2, tot_stores=3
    start_job(16'd2, 16'd3, 1'b1);
    check_eq("y_t0_load", y_load, 1);
    check_eq("y_t0_acc", accumulate, 0);
    pulse_y();
    check_eq("y_first_load", first_load, 1);
    check_eq("y_acc_set", accumulate, 1);
    pulse_w(); pulse_w();
    drain3();
    check_eq("y_acc_keep_buf", accumulate, 1);
    pulse_zf(); pulse_ze();
    check_eq("y_t1_load", y_load, 1);
    check_eq("y_t1_idx", tile_idx, 1);
    pulse_y();
    check_eq("y_t1_skip_first", first_load, 0);
    check_eq("y_t1_computing", w_shift, 1);
    pulse_w(); pulse_w(); drain3(); pulse_zf(); pulse_ze();
    check_eq("y_t2_load", y_load, 1);
    check_eq("y_t2_acc", accumulate, 1);
    pulse_y(); pulse_w(); pulse_w(); drain3(); pulse_zf(); pulse_ze();
    check_eq("y_done", done, 1);
    check_eq("y_done_acc", accumulate, 1);
    tick();
    check_eq("y_acc_end", accumulate, 0);

    // abort in STORING on tile 1, z_empty in the same cycle
    start_job(16'd1, 16'd3, 1'b0);
    pulse_w(); drain3(); pulse_zf(); pulse_ze();
    pulse_w(); drain3(); pulse_zf();
    check_eq("abort_pre_storing", storing, 1);
    check_eq("abort_pre_tile", tile_idx, 1);
    abort = 1'b1; z_empty = 1'b1; tick(); abort = 1'b0; z_empty = 1'b0;
    check_eq("abort_done", done, 1);
    check_eq("abort_flag", aborted, 1);
    check_eq("abort_tile_held", tile_idx, 1);
    repeat (4) tick();
    check_eq("abort_sticky", aborted, 1);
    check_eq("abort_idle_done", done, 0);

    // zero-size jobs; start clears aborted
    start_job(16'd0, 16'd5, 1'b0);
    check_eq("zero_w_done", done, 1);
    check_eq("zero_w_busy", busy, 0);
    check_eq("zero_w_aborted", aborted, 0);
    tick();
    check_eq("zero_w_done_once", done, 0);
    start_job(16'd3, 16'd0, 1'b0);
    check_eq("zero_t_done", done, 1);
    check_eq("zero_t_busy", busy, 0);
    tick();

    // abort in IDLE is ignored
    abort = 1'b1; tick(); abort = 1'b0;
    check_eq("abort_idle_ignored", aborted, 0);

    // async reset mid-job
    start_job(16'd8, 16'd2, 1'b0);
    pulse_w(); pulse_w();
    check_eq("rst_pre_shift", w_shift, 1);
    rst_n = 1'b0; #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_shift", w_shift, 0);
    check_eq("rst_done", done, 0);
    tick(); tick();
    check_eq("rst_no_done", done, 0);
    rst_n = 1'b1;
    tick();

    // synchronous clear mid-job
    start_job(16'd8, 16'd2, 1'b0);
    repeat (5) pulse_w();
    check_eq("clr_pre_acc", accumulate, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    check_eq("clr_busy", busy, 0);
    check_eq("clr_acc", accumulate, 0);
    check_eq("clr_done", done, 0);
    tick();
    check_eq("clr_no_done", done, 0);

    // fresh job after clear
    start_job(16'd1, 16'd1, 1'b0);
    check_eq("fresh_busy", busy, 1);
    pulse_w(); drain3(); pulse_zf(); pulse_ze();
    check_eq("fresh_done", done, 1);
    check_eq("fresh_tile", tile_idx, 1);
    tick();
    check_eq("fresh_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
